// File: rtl/mul_ternary_ctrl_if.sv
// Control/strobe bundle between the ternary polynomial multiplier sequencer and its datapath.
// The abort input exists only when MUL_TERNARY_CTRL_ABORT_EN is defined.
interface mul_ternary_ctrl_if #(
  parameter int PARAM_AW = 8
);
  logic                start;
`ifdef MUL_TERNARY_CTRL_ABORT_EN
  logic                abort;
`endif
  logic                busy;
  logic                done;
  logic                acc_clr;
  logic                a_ren;
  logic [PARAM_AW-1:0] a_addr;
  logic                load_en;
  logic                s_ren;
  logic [PARAM_AW-1:0] s_addr;
  logic                mac_en;
  logic                rot_en;
  logic                res_we;
  logic [PARAM_AW-1:0] res_addr;

`ifdef MUL_TERNARY_CTRL_ABORT_EN
  modport master (
    input  start, abort,
    output busy, done, acc_clr, a_ren, a_addr, load_en,
           s_ren, s_addr, mac_en, rot_en, res_we, res_addr
  );
  modport slave (
    output start, abort,
    input  busy, done, acc_clr, a_ren, a_addr, load_en,
           s_ren, s_addr, mac_en, rot_en, res_we, res_addr
  );
`else
  modport master (
    input  start,
    output busy, done, acc_clr, a_ren, a_addr, load_en,
           s_ren, s_addr, mac_en, rot_en, res_we, res_addr
  );
  modport slave (
    output start,
    input  busy, done, acc_clr, a_ren, a_addr, load_en,
           s_ren, s_addr, mac_en, rot_en, res_we, res_addr
  );
`endif
endinterface

// File: rtl/mul_ternary_ctrl.sv
// Sequencer for a ternary polynomial multiply: LOAD A, MUL/rotate, DRAIN, STORE results, DONE.
// Optional cancel input enabled by defining MUL_TERNARY_CTRL_ABORT_EN.
module mul_ternary_ctrl #(
  parameter int PARAM_N  = 256,
  parameter int PARAM_AW = 8
) (
  input logic               clk,
  input logic               rst,
  mul_ternary_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MUL, S_DRAIN, S_STORE, S_DONE
  } state_t;

  localparam logic [PARAM_AW-1:0] CNT_LAST = PARAM_AW'(PARAM_N - 1);
  localparam logic [PARAM_AW-1:0] CNT_ONE  = PARAM_AW'(1);

  state_t              state_q, state_d;
  logic [PARAM_AW-1:0] cnt_q, cnt_d;
  logic                abort_w;
  logic                kill;

  logic                busy_q, done_q, acc_clr_q;
  logic                a_ren_q, load_en_q;
  logic                s_ren_q, rot_en_q, mac_en_q;
  logic                res_we_q;
  logic [PARAM_AW-1:0] a_addr_q, s_addr_q, res_addr_q;

`ifdef MUL_TERNARY_CTRL_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif
  // Abort only acts on a running operation; in IDLE it merely masks start.
  assign kill = abort_w && (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !abort_w) begin
          state_d = S_LOAD;
          cnt_d   = '0;
        end
      end
      S_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_MUL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_STORE;
        cnt_d   = '0;
      end
      S_STORE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Outputs are decoded from the next state so each strobe lines up with its state cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      acc_clr_q  <= 1'b0;
      a_ren_q    <= 1'b0;
      a_addr_q   <= '0;
      load_en_q  <= 1'b0;
      s_ren_q    <= 1'b0;
      s_addr_q   <= '0;
      rot_en_q   <= 1'b0;
      mac_en_q   <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
      acc_clr_q  <= (state_q == S_IDLE) && (state_d == S_LOAD);
      a_ren_q    <= (state_d == S_LOAD);
      a_addr_q   <= (state_d == S_LOAD) ? cnt_d : '0;
      load_en_q  <= a_ren_q && !kill;
      s_ren_q    <= (state_d == S_MUL);
      s_addr_q   <= (state_d == S_MUL) ? cnt_d : '0;
      rot_en_q   <= (state_d == S_MUL);
      mac_en_q   <= s_ren_q && !kill;
      res_we_q   <= (state_d == S_STORE);
      res_addr_q <= (state_d == S_STORE) ? cnt_d : '0;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.acc_clr  = acc_clr_q;
  assign bus.a_ren    = a_ren_q;
  assign bus.a_addr   = a_addr_q;
  assign bus.load_en  = load_en_q;
  assign bus.s_ren    = s_ren_q;
  assign bus.s_addr   = s_addr_q;
  assign bus.rot_en   = rot_en_q;
  assign bus.mac_en   = mac_en_q;
  assign bus.res_we   = res_we_q;
  assign bus.res_addr = res_addr_q;

endmodule

// File: tb/tb_mul_ternary_ctrl.sv
// Scoreboard bench for mul_ternary_ctrl: a timeline model predicts every output each cycle.
// Abort scenarios are included when MUL_TERNARY_CTRL_ABORT_EN is defined.
module tb_mul_ternary_ctrl;
  localparam int N   = 4;
  localparam int AW  = 2;
  localparam int OW  = 9 + 3 * AW;
  localparam int TOT = 3 * N + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mul_ternary_ctrl_if #(.PARAM_AW(AW)) bus ();

  mul_ternary_ctrl #(.PARAM_N(N), .PARAM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [OW-1:0] exp_q[$];
  int checks    = 0;
  int fails     = 0;
  int exp_done  = 0;
  int seen_done = 0;
  int cyc       = 0;

  function automatic logic [OW-1:0] outs();
    return {bus.busy, bus.done, bus.acc_clr, bus.a_ren, bus.load_en, bus.s_ren,
            bus.mac_en, bus.rot_en, bus.res_we, bus.a_addr, bus.s_addr, bus.res_addr};
  endfunction

  // Expected outputs t cycles into an operation (t=0 means idle).
  function automatic logic [OW-1:0] expect_at(int t);
    logic busy, done, clr, aren, lden, sren, mac, rot, we;
    logic [AW-1:0] aa, sa, ra;
    busy = (t != 0);
    clr  = (t == 1);
    aren = (t >= 1) && (t <= N);
    aa   = aren ? AW'(t - 1) : '0;
    lden = (t >= 2) && (t <= N + 1);
    sren = (t >= N + 1) && (t <= 2 * N);
    sa   = sren ? AW'(t - N - 1) : '0;
    rot  = sren;
    mac  = (t >= N + 2) && (t <= 2 * N + 1);
    we   = (t >= 2 * N + 2) && (t <= 3 * N + 1);
    ra   = we ? AW'(t - 2 * N - 2) : '0;
    done = (t == TOT);
    return {busy, done, clr, aren, lden, sren, mac, rot, we, aa, sa, ra};
  endfunction

  task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Reference model: cycle offset since the accepted start.
  initial begin
    int  t;
    logic ab;
    t = 0;
    forever begin
      @(posedge clk);
      cyc++;
`ifdef MUL_TERNARY_CTRL_ABORT_EN
      ab = bus.abort;
`else
      ab = 1'b0;
`endif
      if (!rst)                t = 0;
      else if (ab && t != 0)   t = 0;
      else if (t == 0)         t = (bus.start && !ab) ? 1 : 0;
      else if (t == TOT)       t = 0;
      else                     t = t + 1;
      if (t == TOT) exp_done++;
      exp_q.push_back(expect_at(t));
    end
  end

  // Monitor
  initial begin
    logic [OW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("outputs", outs(), e);
        if (bus.done) seen_done++;
      end
    end
  end

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
`ifdef MUL_TERNARY_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1 rst = 1'b0;
    #1 chk("reset_state", outs(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // single operation
    @(negedge clk);
    start_pulse();
    repeat (20) @(negedge clk);

    // start held high: back-to-back runs
    bus.start = 1'b1;
    repeat (32) @(negedge clk);
    bus.start = 1'b0;
    repeat (16) @(negedge clk);

    // asynchronous reset in the MUL phase
    start_pulse();
    repeat (6) @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("async_reset", outs(), '0);
    @(negedge clk);
    rst = 1'b1;
    start_pulse();
    repeat (20) @(negedge clk);

`ifdef MUL_TERNARY_CTRL_ABORT_EN
    // abort during STORE
    start_pulse();
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (20) @(negedge clk);
    // start and abort together in IDLE, then abort alone
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.start = ($urandom_range(0, 3) == 0);
`ifdef MUL_TERNARY_CTRL_ABORT_EN
      bus.abort = ($urandom_range(0, 24) == 0);
`endif
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b0;
        #1 chk("async_reset_rand", outs(), '0);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b0;
`ifdef MUL_TERNARY_CTRL_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (TOT + 6) @(negedge clk);
    #1;
    chk_int("done_count", seen_done, exp_done);
    chk_int("monitor_active", (checks > 500) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/mul_ternary_ctrl.md
MUL_TERNARY_CTRL -- requirements
Module: mul_ternary_ctrl

Interface
REQ-001 SHALL have parameter PARAM_N, default 256, number of polynomial coefficients (power of two, at least 4).
REQ-002 SHALL have parameter PARAM_AW, default 8, coefficient address width, equal to log2(PARAM_N).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request one multiplication, sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel the running operation; present only with the configuration macro.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port acc_clr  output  1  clear the accumulator register bank.
REQ-010 SHALL have ports a_ren (output, 1) and a_addr (output, PARAM_AW): operand-A memory read.
REQ-011 SHALL have port load_en  output  1  enable for the operand-A shift register.
REQ-012 SHALL have ports s_ren (output, 1) and s_addr (output, PARAM_AW): ternary-operand memory read.
REQ-013 SHALL have ports mac_en (output, 1) and rot_en (output, 1): accumulate enable and operand-A rotate enable.
REQ-014 SHALL have ports res_we (output, 1) and res_addr (output, PARAM_AW): result memory write.

Function
REQ-015 SHALL implement the states IDLE, LOAD, MUL, DRAIN, STORE and DONE, with a PARAM_AW-bit counter cnt.
REQ-016 SHALL move IDLE->LOAD on start=1, pulsing acc_clr in the first LOAD cycle and setting cnt=0.
REQ-017 SHALL, in LOAD, drive a_ren=1 and a_addr=cnt, with load_en equal to a_ren delayed by one cycle (1-cycle read latency).
REQ-018 SHALL, in MUL, drive s_ren=1, s_addr=cnt and rot_en=1, with mac_en equal to s_ren delayed by one cycle.
REQ-019 SHALL move LOAD->MUL and MUL->DRAIN when cnt==PARAM_N-1, wrapping cnt to 0; cnt otherwise increments by 1 each cycle.
REQ-020 SHALL hold DRAIN for one cycle so the final mac_en completes, then enter STORE.
REQ-021 SHALL, in STORE, drive res_we=1 and res_addr=cnt, moving to DONE when cnt==PARAM_N-1.
REQ-022 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-023 SHALL, with start sampled at edge 0, occupy LOAD in cycles 1..N, MUL in N+1..2N, DRAIN in 2N+1, STORE in 2N+2..3N+1, and assert done in 3N+2.
REQ-024 SHALL ignore start while busy=1, and SHALL accept a start asserted in the cycle after DONE.
REQ-025 SHALL drive all strobes low in IDLE, and SHALL hold address outputs at 0 whenever their enable is low.

Reset
REQ-026 SHALL, while rst=0, force state=IDLE, cnt=0 and every output (busy, done, acc_clr, a_ren, a_addr, load_en, s_ren, s_addr, mac_en, rot_en, res_we, res_addr) to 0, including the delayed strobes.
REQ-027 SHALL, on reset asserted mid-operation, abandon the operation immediately and without emitting done; the first start after reset release begins a fresh LOAD.

Configuration
REQ-028 SHALL, with MUL_TERNARY_CTRL_ABORT_EN defined, provide the abort port; abort=1 in any busy state SHALL return the block to IDLE on the next edge, with cnt=0, all strobes (including delayed load_en/mac_en) low, and no done pulse.
REQ-029 SHALL, without MUL_TERNARY_CTRL_ABORT_EN, omit the abort port and logic; an operation then ends only via DONE or reset.
REQ-030 SHALL give abort priority over start when both are asserted in the same cycle, and abort in IDLE SHALL have no effect.

Verification
REQ-031 SHALL cover: PARAM_N=4, single start pulse -> a_addr 0,1,2,3 in cycles 1-4; load_en in cycles 2-5; mac_en in cycles 6-9; res_addr 0..3 in cycles 10-13; done=1 only in cycle 14.
REQ-032 SHALL cover: start held high continuously -> back-to-back operations with done in cycles 14 and 29, and no restart while busy.
REQ-033 SHALL cover: rst=0 asserted in cycle 7 (MUL) -> all outputs 0 asynchronously; no done pulse; a new start completes normally.
REQ-034 SHALL cover (macro defined): abort in cycle 11 (STORE) -> busy=0 and res_we=0 in cycle 12, and no done pulse.
REQ-035 SHALL cover (macro defined): start and abort together in IDLE -> block stays IDLE; abort alone in IDLE -> no change.
